// File: rtl/id_stage_pipe_if.sv
// Bus between the IF/ID register, the decode stage and the EX stage.
// The slave modport is the decode stage; the master modport is its environment.
interface id_stage_pipe_if #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
);
   logic [31:0]       instruction;
   logic [DATA_W-1:0] pc_in;
   logic [DATA_W-1:0] reg1;
   logic [DATA_W-1:0] reg2;
   logic              ex_hold;
   logic [REG_AW-1:0] mem_dest;
   logic              mem_wb_en;

   logic [REG_AW-1:0] src1;
   logic [REG_AW-1:0] src2_rf;
   logic              hazard_stall;
   logic              br_taken;
   logic [DATA_W-1:0] br_target;

   logic              ex_valid;
   logic              ex_wb_en;
   logic              ex_mem_r_en;
   logic              ex_mem_w_en;
   logic              ex_is_imm;
   logic [3:0]        ex_cmd;
   logic [DATA_W-1:0] ex_val1;
   logic [DATA_W-1:0] ex_val2;
   logic [DATA_W-1:0] ex_st_val;
   logic [REG_AW-1:0] ex_dest;
   logic [REG_AW-1:0] ex_src1;
   logic [REG_AW-1:0] ex_src2_forw;

   modport slave (
      input  instruction, pc_in, reg1, reg2, ex_hold, mem_dest, mem_wb_en,
      output src1, src2_rf, hazard_stall, br_taken, br_target,
      output ex_valid, ex_wb_en, ex_mem_r_en, ex_mem_w_en, ex_is_imm, ex_cmd,
      output ex_val1, ex_val2, ex_st_val, ex_dest, ex_src1, ex_src2_forw
   );

   modport master (
      output instruction, pc_in, reg1, reg2, ex_hold, mem_dest, mem_wb_en,
      input  src1, src2_rf, hazard_stall, br_taken, br_target,
      input  ex_valid, ex_wb_en, ex_mem_r_en, ex_mem_w_en, ex_is_imm, ex_cmd,
      input  ex_val1, ex_val2, ex_st_val, ex_dest, ex_src1, ex_src2_forw
   );
endinterface

// File: rtl/id_stage_pipe.sv
// Decode stage with ID/EX register: decode, RF addressing, branch resolution,
// load-use / RAW hazard detection and optional wrong-path squash.
module id_stage_pipe #(
   parameter int DATA_W       = 32,
   parameter int REG_AW       = 5,
   parameter int FORWARD_EN   = 1,
   parameter int SQUASH_IN_ID = 1
) (
   input  logic            clk,
   input  logic            rst,
   id_stage_pipe_if.slave  bus
);

   localparam logic [5:0] OP_NOP  = 6'd0;
   localparam logic [5:0] OP_ADD  = 6'd1;
   localparam logic [5:0] OP_SUB  = 6'd3;
   localparam logic [5:0] OP_AND  = 6'd5;
   localparam logic [5:0] OP_OR   = 6'd6;
   localparam logic [5:0] OP_NOR  = 6'd7;
   localparam logic [5:0] OP_XOR  = 6'd8;
   localparam logic [5:0] OP_SLA  = 6'd9;
   localparam logic [5:0] OP_SLL  = 6'd10;
   localparam logic [5:0] OP_SRA  = 6'd11;
   localparam logic [5:0] OP_SRL  = 6'd12;
   localparam logic [5:0] OP_ADDI = 6'd32;
   localparam logic [5:0] OP_SUBI = 6'd33;
   localparam logic [5:0] OP_LD   = 6'd36;
   localparam logic [5:0] OP_ST   = 6'd37;
   localparam logic [5:0] OP_BEZ  = 6'd40;
   localparam logic [5:0] OP_BNE  = 6'd41;
   localparam logic [5:0] OP_JMP  = 6'd42;

   typedef struct packed {
      logic              valid;
      logic              wb_en;
      logic              mem_r_en;
      logic              mem_w_en;
      logic              is_imm;
      logic [3:0]        cmd;
      logic [DATA_W-1:0] val1;
      logic [DATA_W-1:0] val2;
      logic [DATA_W-1:0] st_val;
      logic [REG_AW-1:0] dest;
      logic [REG_AW-1:0] src1;
      logic [REG_AW-1:0] src2_forw;
   } ex_t;

   function automatic ex_t bubble();
      ex_t b;
      b     = '0;
      b.cmd = 4'd1;
      return b;
   endfunction

   function automatic logic signed [DATA_W-1:0] sext(input logic signed [15:0] imm);
      return DATA_W'(imm);
   endfunction

   // Instruction register fields are 5 bits; wider address spaces are zero-filled.
   function automatic logic [REG_AW-1:0] to_addr(input logic [4:0] f);
      logic [REG_AW-1:0] a;
      a      = '0;
      a[4:0] = f;
      return a;
   endfunction

   function automatic logic src_hit(
      input logic [REG_AW-1:0] a,
      input ex_t               ex,
      input logic [REG_AW-1:0] md,
      input logic              mwb,
      input logic              is_cond_br
   );
      logic ex_match;
      ex_match = (a == ex.dest);
      return (a != '0) &&
             ((ex_match && ex.mem_r_en) ||
              (is_cond_br && ex_match && ex.wb_en) ||
              ((FORWARD_EN == 0) && ((ex_match && ex.wb_en) || ((a == md) && mwb))));
   endfunction

   ex_t                ex_q, ex_d;
   logic               squash_q, squash_d;

   logic [5:0]         op;
   logic [3:0]         dec_cmd;
   logic               is_r, is_alui, is_ld, is_st, is_bez, is_bne, is_jmp;
   logic               dec_valid, use_src1, use_src2;
   logic [REG_AW-1:0]  f_dest, f_src1, f_src2, src2_rf;
   logic signed [DATA_W-1:0] imm_ext;
   logic               hazard, br_cond, taken;
   ex_t                dec;

   assign f_dest  = to_addr(bus.instruction[25:21]);
   assign f_src1  = to_addr(bus.instruction[20:16]);
   assign f_src2  = to_addr(bus.instruction[15:11]);
   assign imm_ext = sext(bus.instruction[15:0]);

   // A squashed instruction is decoded as opcode 0, which disables hazards and branches too.
   always_comb begin
      op      = squash_q ? OP_NOP : bus.instruction[31:26];
      dec_cmd = 4'd1;
      is_r    = 1'b0;
      is_alui = 1'b0;
      is_ld   = 1'b0;
      is_st   = 1'b0;
      is_bez  = 1'b0;
      is_bne  = 1'b0;
      is_jmp  = 1'b0;
      case (op)
         OP_ADD:          begin is_r = 1'b1; dec_cmd = 4'd0;  end
         OP_SUB:          begin is_r = 1'b1; dec_cmd = 4'd2;  end
         OP_AND:          begin is_r = 1'b1; dec_cmd = 4'd4;  end
         OP_OR:           begin is_r = 1'b1; dec_cmd = 4'd5;  end
         OP_NOR:          begin is_r = 1'b1; dec_cmd = 4'd6;  end
         OP_XOR:          begin is_r = 1'b1; dec_cmd = 4'd7;  end
         OP_SLA, OP_SLL:  begin is_r = 1'b1; dec_cmd = 4'd8;  end
         OP_SRA:          begin is_r = 1'b1; dec_cmd = 4'd9;  end
         OP_SRL:          begin is_r = 1'b1; dec_cmd = 4'd10; end
         OP_ADDI:         begin is_alui = 1'b1; dec_cmd = 4'd0; end
         OP_SUBI:         begin is_alui = 1'b1; dec_cmd = 4'd2; end
         OP_LD:           begin is_ld = 1'b1; dec_cmd = 4'd0; end
         OP_ST:           begin is_st = 1'b1; dec_cmd = 4'd0; end
         OP_BEZ:          is_bez = 1'b1;
         OP_BNE:          is_bne = 1'b1;
         OP_JMP:          is_jmp = 1'b1;
         default:         dec_cmd = 4'd1;
      endcase
      dec_valid = is_r | is_alui | is_ld | is_st | is_bez | is_bne | is_jmp;
      use_src1  = dec_valid & ~is_jmp;
      use_src2  = is_r | is_st | is_bne;
      src2_rf   = (is_st | is_bne) ? f_dest : f_src2;
   end

   always_comb begin
      hazard  = (use_src1 && src_hit(f_src1, ex_q, bus.mem_dest, bus.mem_wb_en, is_bez | is_bne)) ||
                (use_src2 && src_hit(src2_rf, ex_q, bus.mem_dest, bus.mem_wb_en, is_bez | is_bne));
      br_cond = (is_bez && (bus.reg1 == '0)) ||
                (is_bne && (bus.reg1 != bus.reg2)) ||
                is_jmp;
      taken   = br_cond && !hazard && !bus.ex_hold && !squash_q;
   end

   always_comb begin
      dec = bubble();
      if (dec_valid) begin
         dec.valid     = 1'b1;
         dec.wb_en     = is_r | is_alui | is_ld;
         dec.mem_r_en  = is_ld;
         dec.mem_w_en  = is_st;
         dec.is_imm    = is_alui | is_ld | is_st;
         dec.cmd       = dec_cmd;
         dec.val1      = bus.reg1;
         dec.val2      = dec.is_imm ? $unsigned(imm_ext) : bus.reg2;
         dec.st_val    = bus.reg2;
         dec.dest      = f_dest;
         dec.src1      = f_src1;
         dec.src2_forw = dec.is_imm ? '0 : f_src2;
      end
   end

   // Hold beats bubble beats load.
   always_comb begin
      if (bus.ex_hold)
         ex_d = ex_q;
      else if (hazard || squash_q)
         ex_d = bubble();
      else
         ex_d = dec;

      squash_d = 1'b0;
      if (SQUASH_IN_ID != 0)
         squash_d = bus.ex_hold ? squash_q : taken;
   end

   // ---- ID/EX register boundary ----
   always_ff @(posedge clk) begin
      if (rst) begin
         ex_q     <= bubble();
         squash_q <= 1'b0;
      end else begin
         ex_q     <= ex_d;
         squash_q <= squash_d;
      end
   end

   assign bus.src1         = f_src1;
   assign bus.src2_rf      = src2_rf;
   assign bus.hazard_stall = hazard;
   assign bus.br_taken     = taken;
   assign bus.br_target    = bus.pc_in + $unsigned(imm_ext);

   assign bus.ex_valid     = ex_q.valid;
   assign bus.ex_wb_en     = ex_q.wb_en;
   assign bus.ex_mem_r_en  = ex_q.mem_r_en;
   assign bus.ex_mem_w_en  = ex_q.mem_w_en;
   assign bus.ex_is_imm    = ex_q.is_imm;
   assign bus.ex_cmd       = ex_q.cmd;
   assign bus.ex_val1      = ex_q.val1;
   assign bus.ex_val2      = ex_q.val2;
   assign bus.ex_st_val    = ex_q.st_val;
   assign bus.ex_dest      = ex_q.dest;
   assign bus.ex_src1      = ex_q.src1;
   assign bus.ex_src2_forw = ex_q.src2_forw;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Bench for id_stage_pipe: forwarding instance checked against a scoreboard of
// expected EX bundles, plus a non-forwarding instance checked with directed values.
module tb_id_stage_pipe;

   typedef struct packed {
      logic        valid;
      logic        wb;
      logic        mr;
      logic        mw;
      logic        im;
      logic [3:0]  cmd;
      logic [31:0] v1;
      logic [31:0] v2;
      logic [31:0] sv;
      logic [4:0]  d;
      logic [4:0]  s1;
      logic [4:0]  s2;
   } exb_t;

   localparam exb_t BUBBLE = {5'b0, 4'd1, 111'b0};

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   id_stage_pipe_if #(.DATA_W(32), .REG_AW(5)) bus ();
   id_stage_pipe_if #(.DATA_W(32), .REG_AW(5)) bus_nf ();

   id_stage_pipe #(.DATA_W(32), .REG_AW(5), .FORWARD_EN(1), .SQUASH_IN_ID(1))
      u_dut (.clk(clk), .rst(rst), .bus(bus));
   id_stage_pipe #(.DATA_W(32), .REG_AW(5), .FORWARD_EN(0), .SQUASH_IN_ID(1))
      u_nf (.clk(clk), .rst(rst), .bus(bus_nf));

   assign bus_nf.instruction = bus.instruction;
   assign bus_nf.pc_in       = bus.pc_in;
   assign bus_nf.reg1        = bus.reg1;
   assign bus_nf.reg2        = bus.reg2;
   assign bus_nf.ex_hold     = bus.ex_hold;
   assign bus_nf.mem_dest    = bus.mem_dest;
   assign bus_nf.mem_wb_en   = bus.mem_wb_en;

   int   n_chk  = 0;
   int   n_fail = 0;
   exb_t sb[$];
   exb_t last_exp;

   task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [31:0] rt(input int op, input int d, input int s1, input int s2);
      return {op[5:0], d[4:0], s1[4:0], s2[4:0], 11'd0};
   endfunction

   function automatic logic [31:0] it(input int op, input int d, input int s1, input logic [15:0] imm);
      return {op[5:0], d[4:0], s1[4:0], imm};
   endfunction

   // Reference decode of one instruction into the bundle EX should see.
   function automatic exb_t model(input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2);
      exb_t       m;
      logic [5:0] op;
      m  = BUBBLE;
      op = ins[31:26];
      case (op)
         6'd1, 6'd32, 6'd36, 6'd37: m.cmd = 4'd0;
         6'd3, 6'd33:               m.cmd = 4'd2;
         6'd5:                      m.cmd = 4'd4;
         6'd6:                      m.cmd = 4'd5;
         6'd7:                      m.cmd = 4'd6;
         6'd8:                      m.cmd = 4'd7;
         6'd9, 6'd10:               m.cmd = 4'd8;
         6'd11:                     m.cmd = 4'd9;
         6'd12:                     m.cmd = 4'd10;
         6'd40, 6'd41, 6'd42:       m.cmd = 4'd1;
         default:                   return m;
      endcase
      m.valid = 1'b1;
      m.wb    = (op <= 6'd12) || (op == 6'd32) || (op == 6'd33) || (op == 6'd36);
      m.mr    = (op == 6'd36);
      m.mw    = (op == 6'd37);
      m.im    = (op == 6'd32) || (op == 6'd33) || (op == 6'd36) || (op == 6'd37);
      m.v1    = r1;
      m.sv    = r2;
      m.d     = ins[25:21];
      m.s1    = ins[20:16];
      m.v2    = m.im ? {{16{ins[15]}}, ins[15:0]} : r2;
      m.s2    = m.im ? 5'd0 : ins[15:11];
      return m;
   endfunction

   function automatic exb_t dut_ex();
      return {bus.ex_valid, bus.ex_wb_en, bus.ex_mem_r_en, bus.ex_mem_w_en, bus.ex_is_imm,
              bus.ex_cmd, bus.ex_val1, bus.ex_val2, bus.ex_st_val,
              bus.ex_dest, bus.ex_src1, bus.ex_src2_forw};
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst             = 1'b1;
      bus.ex_hold     = 1'b1;
      bus.instruction = 32'd0;
      bus.mem_dest    = 5'd0;
      bus.mem_wb_en   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst         = 1'b0;
      bus.ex_hold = 1'b0;
      check("rst_ex_bundle", 128'(dut_ex()), 128'(BUBBLE));
      check("rst_stall", 128'(bus.hazard_stall), 128'(0));
      check("rst_nf_valid", 128'(bus_nf.ex_valid), 128'(0));
      check("rst_nf_cmd", 128'(bus_nf.ex_cmd), 128'(1));
      last_exp = BUBBLE;
      sb.delete();
   endtask

   task automatic cyc(input string tag, input logic [31:0] ins, input logic [31:0] r1,
                      input logic [31:0] r2, input logic hold, input logic x_stall,
                      input logic x_taken, input logic x_bubble, input logic [31:0] x_tgt);
      exb_t nxt, got;
      @(negedge clk);
      bus.instruction = ins;
      bus.reg1        = r1;
      bus.reg2        = r2;
      bus.ex_hold     = hold;
      #1;
      check({tag, "/stall"}, 128'(bus.hazard_stall), 128'(x_stall));
      check({tag, "/taken"}, 128'(bus.br_taken), 128'(x_taken));
      if (x_taken)
         check({tag, "/target"}, 128'(bus.br_target), 128'(x_tgt));
      if (hold)
         nxt = last_exp;
      else if (x_bubble)
         nxt = BUBBLE;
      else
         nxt = model(ins, r1, r2);
      sb.push_back(nxt);
      last_exp = nxt;
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         check({tag, "/sb_empty"}, 128'(1), 128'(0));
      end else begin
         got = sb.pop_front();
         check({tag, "/ex"}, 128'(dut_ex()), 128'(got));
      end
      bus.ex_hold = 1'b0;
   endtask

   task automatic nf_cyc(input string tag, input logic [31:0] ins, input logic hold,
                         input logic [4:0] md, input logic mwb, input logic x_stall,
                         input logic x_valid, input logic [3:0] x_cmd, input logic [4:0] x_dest);
      @(negedge clk);
      bus.instruction = ins;
      bus.reg1        = 32'd5;
      bus.reg2        = 32'd7;
      bus.ex_hold     = hold;
      bus.mem_dest    = md;
      bus.mem_wb_en   = mwb;
      #1;
      check({tag, "/stall"}, 128'(bus_nf.hazard_stall), 128'(x_stall));
      @(posedge clk);
      #1;
      check({tag, "/valid"}, 128'(bus_nf.ex_valid), 128'(x_valid));
      check({tag, "/cmd"}, 128'(bus_nf.ex_cmd), 128'(x_cmd));
      check({tag, "/dest"}, 128'(bus_nf.ex_dest), 128'(x_dest));
      bus.ex_hold = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.instruction = 32'd0;
      bus.pc_in       = 32'd0;
      bus.reg1        = 32'd0;
      bus.reg2        = 32'd0;
      bus.ex_hold     = 1'b0;
      bus.mem_dest    = 5'd0;
      bus.mem_wb_en   = 1'b0;
      do_reset();

      // MEM-stage writer of r1 must not stall when forwarding exists
      bus.mem_dest  = 5'd1;
      bus.mem_wb_en = 1'b1;
      cyc("add", rt(1, 3, 1, 2), 32'd5, 32'd7, 0, 0, 0, 0, 0);
      bus.mem_dest  = 5'd0;
      bus.mem_wb_en = 1'b0;
      check("add_cmd", 128'(bus.ex_cmd), 128'(0));
      check("add_val1", 128'(bus.ex_val1), 128'(5));
      check("add_val2", 128'(bus.ex_val2), 128'(7));
      check("add_dest", 128'(bus.ex_dest), 128'(3));
      check("add_wb", 128'(bus.ex_wb_en), 128'(1));

      cyc("fwd_raw", rt(3, 10, 3, 6), 32'd12, 32'd1, 0, 0, 0, 0, 0);
      cyc("addi", it(32, 6, 1, 16'hFFFF), 32'd5, 32'd7, 0, 0, 0, 0, 0);
      check("addi_val2", 128'(bus.ex_val2), 128'(32'hFFFF_FFFF));
      check("addi_src2f", 128'(bus.ex_src2_forw), 128'(0));

      cyc("ld", it(36, 4, 1, 16'h0008), 32'd100, 32'd0, 0, 0, 0, 0, 0);
      cyc("ld_use", rt(1, 7, 4, 2), 32'd9, 32'd7, 0, 1, 0, 1, 0);
      check("ld_use_mr", 128'(bus.ex_mem_r_en), 128'(0));
      cyc("ld_use_go", rt(1, 7, 4, 2), 32'd9, 32'd7, 0, 0, 0, 0, 0);

      cyc("ld2", it(36, 4, 1, 16'h0000), 32'd100, 32'd0, 0, 0, 0, 0, 0);
      cyc("ld_use_hold", rt(3, 8, 2, 4), 32'd3, 32'd9, 1, 1, 0, 0, 0);
      check("ld_hold_mr", 128'(bus.ex_mem_r_en), 128'(1));
      cyc("ld_use2", rt(3, 8, 2, 4), 32'd3, 32'd9, 0, 1, 0, 1, 0);
      cyc("ld_use2_go", rt(3, 8, 2, 4), 32'd3, 32'd9, 0, 0, 0, 0, 0);

      cyc("ld_r0", it(36, 0, 1, 16'h0000), 32'd100, 32'd0, 0, 0, 0, 0, 0);
      cyc("r0_use", rt(1, 9, 0, 0), 32'd0, 32'd0, 0, 0, 0, 0, 0);

      bus.pc_in = 32'h100;
      cyc("bez_haz", it(40, 0, 9, 16'h0008), 32'd0, 32'd0, 0, 1, 0, 1, 0);
      cyc("bez_tk", it(40, 0, 9, 16'h0008), 32'd0, 32'd0, 0, 0, 1, 0, 32'h108);
      cyc("squash_jmp", it(42, 0, 0, 16'h0020), 32'd0, 32'd0, 0, 0, 0, 1, 0);

      bus.pc_in = 32'h10;
      cyc("bne_tk", it(41, 2, 1, 16'h0004), 32'd1, 32'd2, 0, 0, 1, 0, 32'h14);
      cyc("bne_squash", rt(1, 3, 1, 2), 32'd5, 32'd7, 0, 0, 0, 1, 0);
      cyc("bne_nt", it(41, 2, 1, 16'h0004), 32'd3, 32'd3, 0, 0, 0, 0, 0);

      bus.pc_in = 32'h2;
      cyc("jmp_hold", it(42, 0, 0, 16'hFFFC), 32'd0, 32'd0, 1, 0, 0, 0, 0);
      cyc("jmp_tk", it(42, 0, 0, 16'hFFFC), 32'd0, 32'd0, 0, 0, 1, 0, 32'hFFFF_FFFE);
      cyc("sq_hold", rt(1, 3, 1, 2), 32'd5, 32'd7, 1, 0, 0, 0, 0);
      cyc("sq_bub", rt(1, 3, 1, 2), 32'd5, 32'd7, 0, 0, 0, 1, 0);
      cyc("after_sq", rt(1, 3, 1, 2), 32'd5, 32'd7, 0, 0, 0, 0, 0);
      cyc("undef", rt(50, 3, 1, 2), 32'd5, 32'd7, 0, 0, 0, 0, 0);
      check("undef_valid", 128'(bus.ex_valid), 128'(0));

      // reset arriving while a squash is pending must clear it
      bus.pc_in = 32'h40;
      cyc("jmp_rst", it(42, 0, 0, 16'h0010), 32'd0, 32'd0, 0, 0, 1, 0, 32'h50);
      do_reset();
      cyc("post_rst", rt(1, 3, 1, 2), 32'd5, 32'd7, 0, 0, 0, 0, 0);
      check("post_rst_valid", 128'(bus.ex_valid), 128'(1));

      // no-forwarding instance: EX-stage writer stalls two cycles, MEM-stage one
      do_reset();
      nf_cyc("nf_add", rt(1, 5, 1, 2), 0, 5'd0, 0, 0, 1, 4'd0, 5'd5);
      nf_cyc("nf_sub_hold", rt(3, 6, 5, 2), 1, 5'd0, 0, 1, 1, 4'd0, 5'd5);
      check("nf_hold_val1", 128'(bus_nf.ex_val1), 128'(5));
      nf_cyc("nf_sub_ex", rt(3, 6, 5, 2), 0, 5'd0, 0, 1, 0, 4'd1, 5'd0);
      nf_cyc("nf_sub_mem", rt(3, 6, 5, 2), 0, 5'd5, 1, 1, 0, 4'd1, 5'd0);
      nf_cyc("nf_sub_go", rt(3, 6, 5, 2), 0, 5'd0, 0, 0, 1, 4'd2, 5'd6);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/id_stage_pipe.md
# id_stage_pipe

Parametrised decode stage with an integrated ID/EX pipeline register, in-stage branch resolution, load-use and RAW hazard detection, and optional squash of the wrong-path instruction. It sits between the IF/ID register and the EX stage. It decodes the instruction, drives register-file read addresses, resolves branches against register-file data, and presents a registered EX-stage bundle that supports hold and bubble insertion.

## Interface
- DATA_W, 32: datapath and immediate sign-extension width.
- REG_AW, 5: register address width; instruction fields are fixed, upper bits zero-filled if wider.
- FORWARD_EN, 1: 1 = EX forwarding exists, only load-use stalls; 0 = stall on any RAW against EX or MEM.
- SQUASH_IN_ID, 1: 1 = this block bubbles the instruction following a taken branch; 0 = upstream flushes IF/ID.
- clk  in  1  clock
- rst  in  1  one clock; reset is synchronous and active-high
- instruction  in  32  IF/ID instruction
- pc_in  in  DATA_W  address of the next sequential instruction
- reg1, reg2  in  DATA_W  register-file read data for src1 / src2_rf
- ex_hold  in  1  downstream freeze
- mem_dest  in  REG_AW  MEM-stage destination
- mem_wb_en  in  1  MEM-stage write enable
- src1, src2_rf  out  REG_AW  register-file read addresses (comb)
- hazard_stall  out  1  freeze PC and IF/ID (comb)
- br_taken  out  1  branch taken (comb)
- br_target  out  DATA_W  pc_in + sext(imm) (comb)
- ex_valid, ex_wb_en, ex_mem_r_en, ex_mem_w_en, ex_is_imm  out  1  registered controls
- ex_cmd  out  4  registered ALU command
- ex_val1, ex_val2, ex_st_val  out  DATA_W  registered operands: reg1, reg2 or imm, reg2
- ex_dest, ex_src1, ex_src2_forw  out  REG_AW  registered addresses for WB and forwarding

## Operation
- Fields: op = [31:26], dest = [25:21], src1 = [20:16], src2 = [15:11], imm = [15:0]. src2_rf = [25:21] for ST/BNE, else [15:11].
- Opcode → ex_cmd:
  - R-type: 1 ADD→0, 3 SUB→2, 5 AND→4, 6 OR→5, 7 NOR→6, 8 XOR→7, 9 SLA→8, 10 SLL→8, 11 SRA→9, 12 SRL→10.
  - Immediate: 32 ADDI→0, 33 SUBI→2.
  - Memory: 36 LD→0, 37 ST→0.
  - Branch: 40 BEZ, 41 BNE, 42 JMP.
  - Opcode 0 and any undefined opcode decode as NOP (valid=0, all enables 0, cmd 1).
- wb_en for R-type, immediate and LD. mem_r_en for LD; mem_w_en for ST.
- is_imm for ADDI, SUBI, LD and ST. val2 = sext(imm) when is_imm, else reg2. ex_src2_forw = 0 when is_imm, else src2.
- Source use:
  - src1 is read by everything except NOP and JMP.
  - src2_rf is read by R-type, ST and BNE.
  - Address 0 never creates a hazard.
- Hazard (hazard_stall = 1) when a used source matches one of:
  - ex_dest with ex_mem_r_en (load-use).
  - ex_dest with ex_wb_en, when the current op is BEZ or BNE, in either mode.
  - ex_dest with ex_wb_en, or mem_dest with mem_wb_en, when FORWARD_EN = 0.
- Branch:
  - Conditions: BEZ when reg1 == 0; BNE when reg1 != reg2; JMP always.
  - br_taken is forced to 0 while hazard_stall, ex_hold or squash_q is asserted.
- squash_q register (SQUASH_IN_ID = 1 only):
  - Set on a cycle with br_taken and no ex_hold.
  - Cleared on the next cycle without ex_hold.
  - While set, the current instruction decodes as NOP; hazard and branch logic are suppressed.
  - Tied to 0 when SQUASH_IN_ID = 0.
- ID/EX update priority, per cycle:
  1. rst: all ex_* cleared, squash_q = 0.
  2. ex_hold: all ex_* keep their values.
  3. hazard_stall or squash_q: bubble (ex_valid and all enables 0, other fields 0, cmd 1).
  4. Otherwise: load the decoded bundle.
- Width rule: sext replicates imm[15] to DATA_W. br_target wraps modulo 2^DATA_W.

## Timing
- Decode, hazard and branch outputs are combinational in the ID cycle. The EX bundle appears one cycle later.
- Reset values: ex_valid, ex_wb_en, ex_mem_r_en, ex_mem_w_en, ex_is_imm = 0; ex_cmd = 1; all ex_* data/address fields = 0; squash_q = 0.
- hazard_stall is independent of ex_hold. Upstream freezes on (hazard_stall | ex_hold).
- A load-use hazard stalls exactly one cycle: the bubble clears ex_mem_r_en.
- With FORWARD_EN = 0, a dependence on a MEM-stage writer stalls one cycle; on an EX-stage writer, two cycles.
- rst asserted mid-stall or mid-squash takes effect on that edge. No hazard or squash state survives reset.

## Test plan
- Reset: hold rst 2 cycles → all ex_* zero, ex_cmd = 1, hazard_stall = 0.
- ADD r3,r1,r2 with reg1 = 5, reg2 = 7 → next cycle ex_cmd = 0, ex_val1 = 5, ex_val2 = 7, ex_dest = 3, ex_wb_en = 1.
- ADDI, imm = 0xFFFF, DATA_W = 32 → ex_val2 = 0xFFFFFFFF, ex_src2_forw = 0.
- LD r4, then ADD using r4 → one-cycle hazard_stall and a bubble; on the following cycle the ADD loads normally.
- BNE with reg1 = 1, reg2 = 2, pc_in = 0x10, imm = 4 → br_taken = 1, br_target = 0x14; next instruction bubbled (SQUASH_IN_ID = 1).
- FORWARD_EN = 0, ADD r5 followed by SUB using r5 → stall 2 cycles; ex_hold during a stall keeps ex_* unchanged.
